// File: rtl/pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its consumers.
// The slave modport is the sequencer's view; the master modport drives lock and observes resets.
interface pll_reset_seq_if;
    logic       locked_i;
    logic       rst_early_o;
    logic       rst_late_o;
    logic       ready_o;
    logic [7:0] loss_cnt_o;
    logic       pll_rst_o;

    modport slave (
        input  locked_i,
        output rst_early_o,
        output rst_late_o,
        output ready_o,
        output loss_cnt_o,
        output pll_rst_o
    );

    modport master (
        output locked_i,
        input  rst_early_o,
        input  rst_late_o,
        input  ready_o,
        input  loss_cnt_o,
        input  pll_rst_o
    );
endinterface

// File: rtl/pll_reset_seq.sv
// Sequences early then late system resets from a glitch-filtered PLL lock, on the reference clock.
// Define PLL_RESTART_EN to add lock-timeout PLL restart pulses on pll_rst_o.
module pll_reset_seq #(
    parameter int unsigned LOCK_CYCLES    = 1024,
    parameter int unsigned STAGE_CYCLES   = 256,
    parameter int unsigned DROP_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned RST_PULSE      = 16
) (
    input  logic           clk,
    input  logic           reset,
    pll_reset_seq_if.slave bus
);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_BASE = max_u(max_u(LOCK_CYCLES, STAGE_CYCLES), DROP_CYCLES);
`ifdef PLL_RESTART_EN
    localparam int unsigned MAX_CNT  = max_u(MAX_BASE, max_u(TIMEOUT_CYCLES, RST_PULSE));
`else
    localparam int unsigned MAX_CNT  = MAX_BASE;
`endif
    localparam int unsigned CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST  = CNT_W'(DROP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        StWaitLock,
        StStable,
        StStage,
        StRun
    } state_e;

    state_e           r_state;
    logic             r_sync_meta;
    logic             r_locked_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_rst_early;
    logic             r_rst_late;
    logic             r_ready;
    logic [7:0]       r_loss_cnt;
    logic             w_loss;
    logic             w_hold;

    // Loss fires on the DROP_CYCLES-th consecutive unlocked cycle, not one cycle later.
    assign w_loss = !r_locked_s && (r_drop_cnt == DROP_LAST);

`ifdef PLL_RESTART_EN
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);

    logic             r_pll_rst;
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_pulse_cnt;
    logic             w_tmo_hit;
    logic             w_seeking;

    assign w_seeking = (r_state == StWaitLock) || (r_state == StStable);
    assign w_tmo_hit = !r_pll_rst && w_seeking && (r_tmo == TMO_LAST);
    assign w_hold    = r_pll_rst || w_tmo_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pll_rst   <= 1'b0;
            r_tmo       <= '0;
            r_pulse_cnt <= '0;
        end else if (r_pll_rst) begin
            if (r_pulse_cnt == PULSE_LAST) begin
                r_pll_rst   <= 1'b0;
                r_pulse_cnt <= '0;
            end else begin
                r_pulse_cnt <= r_pulse_cnt + CNT_ONE;
            end
        end else if (w_tmo_hit) begin
            r_pll_rst <= 1'b1;
            r_tmo     <= '0;
        end else if (w_seeking) begin
            r_tmo <= r_tmo + CNT_ONE;
        end else begin
            r_tmo <= '0;
        end
    end

    assign bus.pll_rst_o = r_pll_rst;
`else
    assign w_hold        = 1'b0;
    assign bus.pll_rst_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= StWaitLock;
            r_cnt       <= '0;
            r_drop_cnt  <= '0;
            r_rst_early <= 1'b1;
            r_rst_late  <= 1'b1;
            r_ready     <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            r_sync_meta <= bus.locked_i;
            r_locked_s  <= r_sync_meta;
            if (w_hold) begin
                r_state <= StWaitLock;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    StWaitLock: begin
                        r_cnt <= '0;
                        if (r_locked_s) r_state <= StStable;
                    end
                    StStable: begin
                        if (!r_locked_s) begin
                            r_state <= StWaitLock;
                            r_cnt   <= '0;
                        end else if (r_cnt == LOCK_LAST) begin
                            r_state <= StStage;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    StStage, StRun: begin
                        if (w_loss) begin
                            r_state     <= StWaitLock;
                            r_cnt       <= '0;
                            r_drop_cnt  <= '0;
                            r_rst_early <= 1'b1;
                            r_rst_late  <= 1'b1;
                            r_ready     <= 1'b0;
                            if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
                        end else begin
                            r_drop_cnt <= r_locked_s ? '0 : r_drop_cnt + CNT_ONE;
                            // Stage timing starts once the early reset has actually been released.
                            if (r_state == StStage) begin
                                if (r_rst_early) begin
                                    r_rst_early <= 1'b0;
                                end else if (r_cnt == STAGE_LAST) begin
                                    r_state    <= StRun;
                                    r_cnt      <= '0;
                                    r_rst_late <= 1'b0;
                                    r_ready    <= 1'b1;
                                end else begin
                                    r_cnt <= r_cnt + CNT_ONE;
                                end
                            end
                        end
                    end
                    default: r_state <= StWaitLock;
                endcase
            end
        end
    end

    assign bus.rst_early_o = r_rst_early;
    assign bus.rst_late_o  = r_rst_late;
    assign bus.ready_o     = r_ready;
    assign bus.loss_cnt_o  = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq: expected output changes are queued with their cycle
// when stimulus is driven, and matched as the DUT outputs change.
module tb_pll_reset_seq;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    logic [7:0]  exp_loss;

    typedef struct {
        int unsigned cyc;
        logic [11:0] vals;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] r_prev;
    logic [11:0] w_vals;

    pll_reset_seq_if bus ();

    pll_reset_seq #(
        .LOCK_CYCLES    (16),
        .STAGE_CYCLES   (8),
        .DROP_CYCLES    (4),
        .TIMEOUT_CYCLES (100),
        .RST_PULSE      (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Packed as {pll_rst, ready, late, early, loss[7:0]}.
    task automatic push(input int unsigned c, input logic pll, input logic rdy, input logic late,
                        input logic early, input logic [7:0] loss);
        exp_t e;
        e.cyc  = c;
        e.vals = {pll, rdy, late, early, loss};
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        w_vals = {bus.pll_rst_o, bus.ready_o, bus.rst_late_o, bus.rst_early_o, bus.loss_cnt_o};
        if (!reset && w_vals !== r_prev) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_change", 32'(w_vals), 32'(r_prev));
            end else begin
                e = sb_q.pop_front();
                check_val("event_cycle", e.cyc, cyc);
                check_val("event_outputs", 32'(w_vals), 32'(e.vals));
            end
        end
        r_prev = w_vals;
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input logic lk);
        reset        = 1'b1;
        bus.locked_i = lk;
        repeat (3) @(negedge clk);
        reset    = 1'b0;
        exp_loss = 8'd0;
    endtask

    task automatic drained(input string tag);
        check_val(tag, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        int unsigned c0;
        n_checks     = 0;
        n_fail       = 0;
        exp_loss     = 8'd0;
        reset        = 1'b1;
        bus.locked_i = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_early_reset", 32'(bus.rst_early_o), 1);
        check_val("rst_late_reset", 32'(bus.rst_late_o), 1);
        check_val("ready_reset", 32'(bus.ready_o), 0);
        check_val("loss_reset", 32'(bus.loss_cnt_o), 0);
        check_val("pll_rst_reset", 32'(bus.pll_rst_o), 0);

`ifdef PLL_RESTART_EN
        // Lock timeout pulses; a lock seen during the pulse must be ignored.
        do_reset(1'b0);
        c0 = cyc;
        push(c0 + 100, 1, 0, 1, 1, 8'd0);
        push(c0 + 104, 0, 0, 1, 1, 8'd0);
        push(c0 + 204, 1, 0, 1, 1, 8'd0);
        push(c0 + 208, 0, 0, 1, 1, 8'd0);
        wait_until(c0 + 100);
        bus.locked_i = 1'b1;
        wait_until(c0 + 102);
        bus.locked_i = 1'b0;
        wait_until(c0 + 215);
        drained("restart_drained");
`endif

        // Lock present at reset release: full sequence.
        do_reset(1'b1);
        c0 = cyc;
        push(c0 + 20, 0, 0, 1, 0, exp_loss);
        push(c0 + 28, 0, 1, 0, 0, exp_loss);
        wait_until(c0 + 40);
        drained("seq_drained");

        // Three-cycle drop in RUN is filtered out.
        c0 = cyc;
        bus.locked_i = 1'b0;
        wait_until(c0 + 3);
        bus.locked_i = 1'b1;
        wait_until(c0 + 20);
        drained("drop3_drained");

        // Four-cycle drop in RUN is a loss, then the sequence repeats.
        c0 = cyc;
        bus.locked_i = 1'b0;
        exp_loss = 8'd1;
        push(c0 + 6, 0, 0, 1, 1, exp_loss);
        push(c0 + 24, 0, 0, 1, 0, exp_loss);
        push(c0 + 32, 0, 1, 0, 0, exp_loss);
        wait_until(c0 + 4);
        bus.locked_i = 1'b1;
        wait_until(c0 + 40);
        drained("drop4_drained");

        // Repeated losses saturate the counter while sequencing continues.
        for (int i = 0; i < 260; i++) begin
            c0 = cyc;
            bus.locked_i = 1'b0;
            if (exp_loss != 8'hFF) exp_loss = exp_loss + 8'd1;
            push(c0 + 6, 0, 0, 1, 1, exp_loss);
            push(c0 + 24, 0, 0, 1, 0, exp_loss);
            push(c0 + 32, 0, 1, 0, 0, exp_loss);
            wait_until(c0 + 4);
            bus.locked_i = 1'b1;
            wait_until(c0 + 36);
        end
        drained("sat_drained");
        check_val("loss_saturated", 32'(bus.loss_cnt_o), 255);

        // Reset during STAGE asserts outputs without a clock edge.
        do_reset(1'b1);
        c0 = cyc;
        push(c0 + 20, 0, 0, 1, 0, 8'd0);
        wait_until(c0 + 23);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_early", 32'(bus.rst_early_o), 1);
        check_val("async_rst_late", 32'(bus.rst_late_o), 1);
        check_val("async_ready", 32'(bus.ready_o), 0);
        drained("stage_drained");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        push(c0 + 20, 0, 0, 1, 0, 8'd0);
        push(c0 + 28, 0, 1, 0, 0, 8'd0);
        wait_until(c0 + 40);
        drained("reseq_drained");

        // One-cycle glitch while STABLE at count 10 restarts the lock count.
        do_reset(1'b0);
        c0 = cyc;
        bus.locked_i = 1'b1;
        push(c0 + 32, 0, 0, 1, 0, 8'd0);
        push(c0 + 40, 0, 1, 0, 0, 8'd0);
        wait_until(c0 + 11);
        bus.locked_i = 1'b0;
        @(negedge clk);
        bus.locked_i = 1'b1;
        wait_until(c0 + 50);
        drained("glitch_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
